id_ex_reg: RTL and testbench

ID/EX pipeline stage of the RISC-V core, sitting directly downstream of `Register_File` and the decoder. It captures decoded control fields and the two register-file read operands into the EX stage. Because `Register_File` has no internal write-through, it applies a writeback-to-decode bypass. It also detects load-use hazards, inserting a bubble and stalling upstream, and honours EX stall and branch flush requests.

---
 rtl/id_ex_reg.sv | 125 ++++++++++++
 tb/tb_id_ex_reg.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - ID/EX pipeline register with WB-to-decode bypass, load-use bubble, stall and flush
module id_ex_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             a_reset_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_pc,
  input  logic [WIDTH-1:0] i_imm,
  input  logic [4:0]       i_rs1,
  input  logic [4:0]       i_rs2,
  input  logic [4:0]       i_rd,
  input  logic [WIDTH-1:0] i_rs1_data,
  input  logic [WIDTH-1:0] i_rs2_data,
  input  logic [3:0]       i_alu_op,
  input  logic             i_alu_src,
  input  logic             i_mem_read,
  input  logic             i_mem_write,
  input  logic             i_regwrite,
  input  logic             i_mem_to_reg,
  input  logic             i_branch,
  input  logic             i_wb_regwrite,
  input  logic [4:0]       i_wb_rd,
  input  logic [WIDTH-1:0] i_wb_data,
  input  logic             i_ex_stall,
  input  logic             i_flush,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_pc,
  output logic [WIDTH-1:0] o_imm,
  output logic [WIDTH-1:0] o_rs1_data,
  output logic [WIDTH-1:0] o_rs2_data,
  output logic [4:0]       o_rs1,
  output logic [4:0]       o_rs2,
  output logic [4:0]       o_rd,
  output logic [3:0]       o_alu_op,
  output logic             o_alu_src,
  output logic             o_mem_read,
  output logic             o_mem_write,
  output logic             o_regwrite,
  output logic             o_mem_to_reg,
  output logic             o_branch,
  output logic             o_stall
);

  logic             r_valid, r_alu_src, r_mem_read, r_mem_write, r_regwrite, r_mem_to_reg, r_branch;
  logic [WIDTH-1:0] r_pc, r_imm, r_rs1_data, r_rs2_data;
  logic [4:0]       r_rs1, r_rs2, r_rd;
  logic [3:0]       r_alu_op;

  logic             w_wb_nz, w_bp1, w_bp2, w_hold_rf1, w_hold_rf2, w_lu, w_kill, w_ctl_en;
  logic [WIDTH-1:0] w_rs1_data, w_rs2_data;

  // Register_File has no write-through, so a same-cycle WB write is bypassed here
  assign w_wb_nz    = i_wb_regwrite && (i_wb_rd != 5'd0);
  assign w_bp1      = w_wb_nz && (i_wb_rd == i_rs1);
  assign w_bp2      = w_wb_nz && (i_wb_rd == i_rs2);
  assign w_hold_rf1 = w_wb_nz && (i_wb_rd == r_rs1);
  assign w_hold_rf2 = w_wb_nz && (i_wb_rd == r_rs2);
  assign w_rs1_data = w_bp1 ? i_wb_data : i_rs1_data;
  assign w_rs2_data = w_bp2 ? i_wb_data : i_rs2_data;

  assign w_lu     = r_valid && r_mem_read && (r_rd != 5'd0) && i_valid &&
                    ((i_rs1 == r_rd) || (i_rs2 == r_rd));
  assign w_kill   = i_flush || w_lu;
  assign w_ctl_en = i_valid && !w_kill;
  assign o_stall  = !i_flush && (i_ex_stall || w_lu);

  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_imm        <= '0;
      r_rs1_data   <= '0;
      r_rs2_data   <= '0;
      r_rs1        <= 5'd0;
      r_rs2        <= 5'd0;
      r_rd         <= 5'd0;
      r_alu_op     <= 4'd0;
      r_alu_src    <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_regwrite   <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_branch     <= 1'b0;
    end else if (i_ex_stall && !i_flush) begin
      // Held operands track WB writes so they are not stale when the stall releases
      if (w_hold_rf1) r_rs1_data <= i_wb_data;
      if (w_hold_rf2) r_rs2_data <= i_wb_data;
    end else begin
      // Flush and load-use bubble both clear valid/controls; data fields load regardless
      r_valid      <= w_ctl_en;
      r_pc         <= i_pc;
      r_imm        <= i_imm;
      r_rs1_data   <= w_rs1_data;
      r_rs2_data   <= w_rs2_data;
      r_rs1        <= i_rs1;
      r_rs2        <= i_rs2;
      r_rd         <= i_rd;
      r_alu_op     <= w_ctl_en ? i_alu_op : 4'd0;
      r_alu_src    <= w_ctl_en && i_alu_src;
      r_mem_read   <= w_ctl_en && i_mem_read;
      r_mem_write  <= w_ctl_en && i_mem_write;
      r_regwrite   <= w_ctl_en && i_regwrite;
      r_mem_to_reg <= w_ctl_en && i_mem_to_reg;
      r_branch     <= w_ctl_en && i_branch;
    end
  end

  assign o_valid      = r_valid;
  assign o_pc         = r_pc;
  assign o_imm        = r_imm;
  assign o_rs1_data   = r_rs1_data;
  assign o_rs2_data   = r_rs2_data;
  assign o_rs1        = r_rs1;
  assign o_rs2        = r_rs2;
  assign o_rd         = r_rd;
  assign o_alu_op     = r_alu_op;
  assign o_alu_src    = r_alu_src;
  assign o_mem_read   = r_mem_read;
  assign o_mem_write  = r_mem_write;
  assign o_regwrite   = r_regwrite;
  assign o_mem_to_reg = r_mem_to_reg;
  assign o_branch     = r_branch;

endmodule

// File: tb/tb_id_ex_reg.sv
// tb/tb_id_ex_reg.sv - scoreboard bench for id_ex_reg
module tb_id_ex_reg;

  logic        clk = 1'b0;
  logic        a_reset_n;
  logic        i_valid;
  logic [31:0] i_pc, i_imm, i_rs1_data, i_rs2_data, i_wb_data;
  logic [4:0]  i_rs1, i_rs2, i_rd, i_wb_rd;
  logic [3:0]  i_alu_op;
  logic        i_alu_src, i_mem_read, i_mem_write, i_regwrite, i_mem_to_reg, i_branch;
  logic        i_wb_regwrite, i_ex_stall, i_flush;
  logic        o_valid;
  logic [31:0] o_pc, o_imm, o_rs1_data, o_rs2_data;
  logic [4:0]  o_rs1, o_rs2, o_rd;
  logic [3:0]  o_alu_op;
  logic        o_alu_src, o_mem_read, o_mem_write, o_regwrite, o_mem_to_reg, o_branch, o_stall;

  id_ex_reg #(.WIDTH(32)) dut (
    .clk(clk), .a_reset_n(a_reset_n), .i_valid(i_valid), .i_pc(i_pc), .i_imm(i_imm),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
    .i_alu_op(i_alu_op), .i_alu_src(i_alu_src), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
    .i_regwrite(i_regwrite), .i_mem_to_reg(i_mem_to_reg), .i_branch(i_branch),
    .i_wb_regwrite(i_wb_regwrite), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
    .i_ex_stall(i_ex_stall), .i_flush(i_flush),
    .o_valid(o_valid), .o_pc(o_pc), .o_imm(o_imm), .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data),
    .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd), .o_alu_op(o_alu_op), .o_alu_src(o_alu_src),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_regwrite(o_regwrite),
    .o_mem_to_reg(o_mem_to_reg), .o_branch(o_branch), .o_stall(o_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        chk_data;
    logic        valid;
    logic [31:0] pc, imm, rs1_data, rs2_data;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu_op;
    logic        alu_src, mem_read, mem_write, regwrite, mem_to_reg, branch;
  } exp_t;

  exp_t sb_q[$];
  exp_t last;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic dec(input logic v, input logic [31:0] pc, input logic [4:0] rs1, rs2, rd,
                     input logic [31:0] d1, d2, imm, input logic [3:0] op,
                     input logic asrc, mr, mw, rw, m2r, br);
    i_valid = v; i_pc = pc; i_rs1 = rs1; i_rs2 = rs2; i_rd = rd;
    i_rs1_data = d1; i_rs2_data = d2; i_imm = imm; i_alu_op = op;
    i_alu_src = asrc; i_mem_read = mr; i_mem_write = mw; i_regwrite = rw;
    i_mem_to_reg = m2r; i_branch = br;
  endtask

  task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] d);
    i_wb_regwrite = we; i_wb_rd = rd; i_wb_data = d;
  endtask

  // Expected load of the currently driven decode fields, with operand values given by the caller
  function automatic exp_t exp_ld(input logic [31:0] e1, input logic [31:0] e2);
    exp_t e;
    e.chk_data = 1'b1; e.valid = i_valid; e.pc = i_pc; e.imm = i_imm;
    e.rs1_data = e1; e.rs2_data = e2; e.rs1 = i_rs1; e.rs2 = i_rs2; e.rd = i_rd;
    e.alu_op = i_alu_op; e.alu_src = i_alu_src; e.mem_read = i_mem_read;
    e.mem_write = i_mem_write; e.regwrite = i_regwrite; e.mem_to_reg = i_mem_to_reg;
    e.branch = i_branch;
    return e;
  endfunction

  function automatic exp_t exp_bubble();
    exp_t e;
    e = '{default: '0};
    return e;
  endfunction

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check("valid", o_valid, e.valid);
      check("alu_op", o_alu_op, e.alu_op);
      check("ctl", {o_alu_src, o_mem_read, o_mem_write, o_regwrite, o_mem_to_reg, o_branch},
            {e.alu_src, e.mem_read, e.mem_write, e.regwrite, e.mem_to_reg, e.branch});
      if (e.chk_data) begin
        check("pc", o_pc, e.pc);
        check("imm", o_imm, e.imm);
        check("idx", {o_rs1, o_rs2, o_rd}, {e.rs1, e.rs2, e.rd});
        check("rs1_data", o_rs1_data, e.rs1_data);
        check("rs2_data", o_rs2_data, e.rs2_data);
        last = e;
      end
      if (!o_valid)
        check("inv_ctl", {o_regwrite, o_mem_read, o_mem_write, o_branch}, 4'd0);
    end
  endtask

  task automatic check_zero(input string tag);
    check(tag, {o_valid, o_alu_op, o_alu_src, o_mem_read, o_mem_write, o_regwrite, o_mem_to_reg,
                o_branch, o_rs1, o_rs2, o_rd}, 32'd0);
    check({tag, "_data"}, o_pc | o_imm | o_rs1_data | o_rs2_data, 32'd0);
    check({tag, "_stall"}, o_stall, 1'b0);
  endtask

  initial begin
    exp_t e;
    a_reset_n = 1'b0; i_ex_stall = 1'b0; i_flush = 1'b0;
    dec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    wb(0, 0, 0);
    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    a_reset_n = 1'b1;

    // add x3,x1,x2
    dec(1, 32'h100, 1, 2, 3, 5, 7, 0, 4'd0, 0, 0, 0, 1, 0, 0);
    #1 check("stall_add", o_stall, 1'b0);
    sb_q.push_back(exp_ld(5, 7)); tick();

    // WB bypass on rs1
    dec(1, 32'h104, 4, 6, 7, 32'h11, 32'h22, 32'h4, 4'd2, 1, 0, 0, 1, 0, 0);
    wb(1, 4, 32'hAB);
    sb_q.push_back(exp_ld(32'hAB, 32'h22)); tick();

    // x0 is never bypassed
    dec(1, 32'h108, 0, 0, 8, 32'h33, 32'h44, 0, 4'd3, 0, 0, 0, 1, 0, 0);
    wb(1, 0, 32'hAB);
    sb_q.push_back(exp_ld(32'h33, 32'h44)); tick();

    // WB bypass on rs2 with a branch
    dec(1, 32'h10C, 2, 9, 0, 32'h1, 32'h2, 32'hFFFF_FFF0, 4'd1, 0, 0, 0, 0, 0, 1);
    wb(1, 9, 32'hCD);
    sb_q.push_back(exp_ld(32'h1, 32'hCD)); tick();

    // lw x5 then dependent add x6,x1,x5: one bubble
    wb(0, 0, 0);
    dec(1, 32'h110, 1, 0, 5, 32'h1000, 0, 8, 4'd0, 1, 1, 0, 1, 1, 0);
    sb_q.push_back(exp_ld(32'h1000, 0)); tick();
    dec(1, 32'h114, 1, 5, 6, 32'h10, 32'h20, 0, 4'd0, 0, 0, 0, 1, 0, 0);
    #1 check("stall_lu", o_stall, 1'b1);
    e = exp_bubble(); sb_q.push_back(e); tick();
    check("stall_after_bubble", o_stall, 1'b0);
    sb_q.push_back(exp_ld(32'h10, 32'h20)); tick();

    // EX stall for 3 cycles, WB refreshes o_rs1's register on cycle 2
    i_ex_stall = 1'b1;
    dec(1, 32'h200, 7, 8, 9, 32'h99, 32'h98, 0, 4'd5, 0, 0, 1, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) wb(1, 1, 32'h55); else wb(0, 0, 0);
      #1 check("stall_hold", o_stall, 1'b1);
      e = last;
      if (c == 1) e.rs1_data = 32'h55;
      sb_q.push_back(e); tick();
    end
    i_ex_stall = 1'b0; wb(0, 0, 0);

    // Load in EX + dependent decode + EX stall: hold, then flush wins
    dec(1, 32'h120, 2, 0, 5, 32'h2000, 0, 4, 4'd0, 1, 1, 0, 1, 1, 0);
    sb_q.push_back(exp_ld(32'h2000, 0)); tick();
    dec(1, 32'h124, 5, 3, 10, 32'h7, 32'h8, 0, 4'd0, 0, 0, 1, 0, 0, 0);
    i_ex_stall = 1'b1;
    #1 check("stall_lu_ex", o_stall, 1'b1);
    sb_q.push_back(last); tick();
    i_flush = 1'b1;
    #1 check("stall_flush", o_stall, 1'b0);
    e = exp_bubble(); sb_q.push_back(e); tick();
    i_flush = 1'b0; i_ex_stall = 1'b0;
    #1 check("stall_post_flush", o_stall, 1'b0);
    sb_q.push_back(exp_ld(32'h7, 32'h8)); tick();

    // Async reset pulsed mid-hold
    i_ex_stall = 1'b1;
    sb_q.push_back(last); tick();
    #2 a_reset_n = 1'b0; i_ex_stall = 1'b0;
    #1 check_zero("async_reset");
    #1 a_reset_n = 1'b1;
    sb_q.push_back(exp_ld(32'h7, 32'h8)); tick();

    check("sb_drained", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=%0d exp=0", 1);
    $fatal(1);
  end

endmodule
